// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control sequencer.
//   - opcode constants and opcode-class decode helper
//   - FSM state encoding
//   - default program-counter width
package ctrl_pkg;

    localparam int PC_W_DEFAULT = 8;

    localparam logic [3:0] OP_JMP  = 4'd2;
    localparam logic [3:0] OP_JZ   = 4'd3;
    localparam logic [3:0] OP_JNZ  = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd11;
    localparam logic [3:0] OP_LD   = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_WRITE, C_JUMP, C_STORE, C_LOAD, C_HALT
    } op_class_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        case (op)
            4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10: op_class = C_WRITE;
            OP_JMP, OP_JZ, OP_JNZ:               op_class = C_JUMP;
            OP_ST:                               op_class = C_STORE;
            OP_LD:                               op_class = C_LOAD;
            OP_HALT:                             op_class = C_HALT;
            default:                             op_class = C_NOP;
        endcase
    endfunction

endpackage

// File: rtl/pc_unit.sv
// pc_unit: program counter register.
//   clk, reset : clock, async active-high reset (pc -> 0)
//   clr        : synchronous clear to 0 (highest priority)
//   ld, target : load jump target
//   inc        : increment, wrapping modulo 2^PC_W
//   pc         : current program counter
module pc_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            ld,
    input  logic            inc,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      pc <= '0;
        else if (clr)   pc <= '0;
        else if (ld)    pc <= target;
        else if (inc)   pc <= pc + PC_W'(1);
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle instruction sequencer.
//   clk, reset            : clock, async active-high reset
//   start                 : begin execution at pc 0 (IDLE only)
//   imem_req/addr/ack/data: instruction fetch handshake
//   dmem_req/we/ack       : data memory handshake (we=1 store)
//   zero_flag             : datapath status for conditional jumps
//   inst                  : instruction register
//   reg_we                : one-cycle register-file write strobe
//   pc, halted, retired   : program counter, halt status, saturating retire count
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_data,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             zero_flag,
    output logic [15:0]      inst,
    output logic             reg_we,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t     state_q, state_d;
    logic [3:0] op;
    logic       pc_clr, pc_ld, pc_inc, inst_ld, retire, taken;

    assign op = inst[15:12];

    pc_unit #(.PC_W(PC_W)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .clr    (pc_clr),
        .ld     (pc_ld),
        .inc    (pc_inc),
        .target (inst[PC_W-1:0]),
        .pc     (pc)
    );

    // Branch condition, evaluated with zero_flag as seen in the EXEC cycle.
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = zero_flag;
            OP_JNZ:  taken = ~zero_flag;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pc_clr  = 1'b0;
        pc_ld   = 1'b0;
        pc_inc  = 1'b0;
        inst_ld = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                pc_clr  = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: if (imem_ack) begin
                inst_ld = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op_class(op))
                    C_HALT:           begin state_d = S_HALT; retire = 1'b1; end
                    C_JUMP:           state_d = S_EXEC;
                    C_STORE, C_LOAD:  state_d = S_MEM;
                    C_WRITE:          state_d = S_WB;
                    default: begin
                        pc_inc  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                pc_ld   = taken;
                pc_inc  = ~taken;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM: if (dmem_ack) begin
                if (op == OP_ST) begin
                    pc_inc  = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_inc  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        inst <= '0;
        else if (inst_ld) inst <= imem_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         retired <= '0;
        else if (retire && ~&retired)      retired <= retired + CNT_W'(1);
    end

    // Handshake and strobe outputs decode straight from the state register,
    // so a reset drops them in the same instant it takes effect.
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state_q == S_MEM);
    assign dmem_we   = (state_q == S_MEM) && (op == OP_ST);
    assign reg_we    = (state_q == S_WB);
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    localparam int PC_W  = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ack = 1'b0;
    logic [15:0]      imem_data;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             zero_flag = 1'b0;
    logic [15:0]      inst;
    logic             reg_we;
    logic [PC_W-1:0]  pc;
    logic             halted;
    logic [CNT_W-1:0] retired;

    logic [15:0] rom [0:255];
    logic        dack_resp = 1'b0;
    logic        dack_stray = 1'b0;

    assign imem_data = rom[imem_addr];
    assign dmem_ack  = dack_resp | dack_stray;

    control_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .zero_flag(zero_flag), .inst(inst), .reg_we(reg_we), .pc(pc),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp_v);
        end
    endtask

    // ---------------- memory responders (stimulus) ----------------
    int idly = 1, ddly = 1;
    int icnt = 0, dcnt = 0;
    logic i_nxt = 1'b0, d_nxt = 1'b0;

    // Ack comes after the request has been seen for idly/ddly cycles.
    always @(negedge clk) begin
        if (reset || !imem_req || imem_ack) begin
            icnt  <= 0;
            i_nxt <= 1'b0;
        end else begin
            icnt  <= icnt + 1;
            i_nxt <= (icnt + 1 >= idly);
        end
        if (reset || !dmem_req || dack_resp) begin
            dcnt  <= 0;
            d_nxt <= 1'b0;
        end else begin
            dcnt  <= dcnt + 1;
            d_nxt <= (dcnt + 1 >= ddly);
        end
    end

    always @(posedge clk) begin
        #1;
        imem_ack  = i_nxt;
        dack_resp = d_nxt;
    end

    // ---------------- behavioural model state ----------------
    logic [PC_W-1:0]  m_pc;
    logic [15:0]      m_inst;
    logic [CNT_W-1:0] m_ret;
    logic e_ireq, e_dreq, e_dwe, e_rwe, e_halt;
    logic chk_en = 1'b0;
    int   mcyc;
    int   we_cyc[$];

    task automatic set_exp(input logic ir, input logic dr, input logic dw, input logic rw, input logic h);
        e_ireq = ir; e_dreq = dr; e_dwe = dw; e_rwe = rw; e_halt = h;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        mcyc++;
    endtask

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Compare process: every enabled cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", 32'(imem_req), 32'(e_ireq));
            chk("dmem_req", 32'(dmem_req), 32'(e_dreq));
            if (e_dreq) chk("dmem_we", 32'(dmem_we), 32'(e_dwe));
            chk("reg_we", 32'(reg_we), 32'(e_rwe));
            chk("halted", 32'(halted), 32'(e_halt));
            chk("pc", 32'(pc), 32'(m_pc));
            if (e_ireq) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("inst", 32'(inst), 32'(m_inst));
            chk("retired", 32'(retired), 32'(m_ret));
        end
    end

    // Data-request run lengths and register-write ordering.
    int   run = 0;
    logic run_we = 1'b0;
    int   runs[$];
    logic wes[$];
    int   rwe_n = 0, rwe_at = -1;
    always @(negedge clk) begin
        if (dmem_req) begin
            run    = run + 1;
            run_we = dmem_we;
        end else if (run != 0) begin
            runs.push_back(run);
            wes.push_back(run_we);
            run = 0;
        end
        if (reg_we) begin
            rwe_n  = rwe_n + 1;
            rwe_at = runs.size();
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        start  = 1'b0;
        m_pc   = '0;
        m_inst = '0;
        m_ret  = '0;
        set_exp(0, 0, 0, 0, 0);
        chk_en = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic adv();
        m_pc  = m_pc + PC_W'(1);
        m_ret = sat_inc(m_ret);
    endtask

    task automatic wb();
        set_exp(0, 0, 0, 1, 0);
        we_cyc.push_back(mcyc);
        cyc();
        adv();
    endtask

    // Instruction-level interpreter with cycle timing: walks the program as
    // the rules describe (fetch wait, decode, class-specific steps) and
    // publishes what each cycle's outputs must be.
    task automatic run_prog(input int max_instr, input int spi, output logic hit_halt);
        int w;
        logic ack, zf, tk;
        logic [3:0] op;
        hit_halt = 1'b0;
        we_cyc.delete();
        mcyc = 0;
        set_exp(0, 0, 0, 0, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        m_pc = '0;
        for (int n = 0; n < max_instr && !hit_halt; n++) begin
            w = 0;
            do begin
                set_exp(1, 0, 0, 0, 0);
                start = (n == spi && w == 0);
                ack = imem_ack;
                cyc();
                w++;
                if (w > 3000) begin
                    chk("fetch_timeout", 32'(w), 32'd0);
                    start = 1'b0;
                    return;
                end
            end while (!ack);
            start  = 1'b0;
            m_inst = rom[m_pc];
            op     = m_inst[15:12];
            set_exp(0, 0, 0, 0, 0);
            cyc();
            if (op == 4'd15) begin
                m_ret    = sat_inc(m_ret);
                hit_halt = 1'b1;
            end else if (op inside {4'd2, 4'd3, 4'd4}) begin
                set_exp(0, 0, 0, 0, 0);
                zf = zero_flag;
                cyc();
                tk    = (op == 4'd2) || (op == 4'd3 && zf) || (op == 4'd4 && !zf);
                m_pc  = tk ? m_inst[PC_W-1:0] : m_pc + PC_W'(1);
                m_ret = sat_inc(m_ret);
            end else if (op == 4'd11 || op == 4'd12) begin
                w = 0;
                do begin
                    set_exp(0, 1, op == 4'd11, 0, 0);
                    ack = dmem_ack;
                    cyc();
                    w++;
                    if (w > 3000) begin
                        chk("dmem_timeout", 32'(w), 32'd0);
                        return;
                    end
                end while (!ack);
                if (op == 4'd12) wb();
                else             adv();
            end else if (op inside {4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10}) begin
                wb();
            end else begin
                adv();
            end
        end
        if (hit_halt) set_exp(0, 0, 0, 0, 1);
        else          set_exp(1, 0, 0, 0, 0);
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    endtask

    task automatic halt_hold(input int n);
        for (int k = 0; k < n; k++) begin
            start = (k == 1);
            cyc();
        end
        start = 1'b0;
    endtask

    logic hh;

    initial begin
        clear_rom();
        #1;
        do_reset();
        // reset state, explicit
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_inst", 32'(inst), 32'd0);

        // write, write, halt with zero-wait acks
        rom[0] = 16'h9005; rom[1] = 16'h1123; rom[2] = 16'hF000;
        run_prog(10, -1, hh);
        chk("p1_halt_reached", 32'(hh), 32'd1);
        chk("p1_wb_count", 32'(we_cyc.size()), 32'd2);
        if (we_cyc.size() == 2) begin
            chk("p1_wb_cycle0", 32'(we_cyc[0]), 32'd4);
            chk("p1_wb_cycle1", 32'(we_cyc[1]), 32'd8);
        end
        chk("p1_halted", 32'(halted), 32'd1);
        chk("p1_retired", 32'(retired), 32'd3);
        chk("p1_pc", 32'(pc), 32'd2);
        halt_hold(4);

        // jumps with zero_flag=0
        do_reset();
        clear_rom();
        zero_flag = 1'b0;
        rom[0] = 16'h2010; rom[8'h10] = 16'h3020; rom[8'h11] = 16'h4020; rom[8'h20] = 16'hF000;
        run_prog(10, -1, hh);
        chk("p2_pc", 32'(pc), 32'h20);
        chk("p2_retired", 32'(retired), 32'd4);

        // jumps with zero_flag=1
        do_reset();
        clear_rom();
        zero_flag = 1'b1;
        rom[0] = 16'h3005; rom[5] = 16'h4007; rom[6] = 16'hF000;
        run_prog(10, -1, hh);
        chk("p3_pc", 32'(pc), 32'd6);
        chk("p3_retired", 32'(retired), 32'd3);
        zero_flag = 1'b0;

        // store then load, data ack after 3 cycles
        do_reset();
        clear_rom();
        ddly = 3;
        runs.delete(); wes.delete(); rwe_n = 0; rwe_at = -1;
        rom[0] = 16'hB000; rom[1] = 16'hC000; rom[2] = 16'hF000;
        run_prog(10, -1, hh);
        chk("p4_runs", 32'(runs.size()), 32'd2);
        if (runs.size() == 2) begin
            chk("p4_run0_len", 32'(runs[0]), 32'd4);
            chk("p4_run1_len", 32'(runs[1]), 32'd4);
            chk("p4_run0_we", 32'(wes[0]), 32'd1);
            chk("p4_run1_we", 32'(wes[1]), 32'd0);
        end
        chk("p4_reg_we_n", 32'(rwe_n), 32'd1);
        chk("p4_reg_we_after_load", 32'(rwe_at), 32'd2);
        chk("p4_retired", 32'(retired), 32'd3);
        ddly = 1;

        // pc wrap: NOP at 0xFF
        do_reset();
        clear_rom();
        rom[0] = 16'h20FF; rom[8'hFF] = 16'h0000;
        run_prog(2, -1, hh);
        chk("p5_addr_wrap", 32'(imem_addr), 32'd0);
        chk("p5_retired", 32'(retired), 32'd2);

        // reset mid-MEM, stray ack afterwards
        do_reset();
        clear_rom();
        chk_en = 1'b0;
        ddly = 100;
        rom[0] = 16'h0000; rom[1] = 16'h8000; rom[2] = 16'hB000;
        start = 1'b1;
        cyc();
        start = 1'b0;
        begin : wait_mem
            for (int k = 0; k < 40; k++) begin
                if (dmem_req) disable wait_mem;
                cyc();
            end
        end
        chk("p6_in_mem", 32'(dmem_req), 32'd1);
        chk("p6_pc_before", 32'(pc), 32'd2);
        chk("p6_ret_before", 32'(retired), 32'd2);
        cyc();
        reset = 1'b1;
        #1;
        chk("p6_dmem_req_drop", 32'(dmem_req), 32'd0);
        chk("p6_pc_clear", 32'(pc), 32'd0);
        chk("p6_ret_clear", 32'(retired), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        dack_stray = 1'b1;
        cyc();
        dack_stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("p6_idle_imem_req", 32'(imem_req), 32'd0);
            chk("p6_idle_dmem_req", 32'(dmem_req), 32'd0);
            chk("p6_idle_pc", 32'(pc), 32'd0);
            chk("p6_idle_halted", 32'(halted), 32'd0);
        end
        ddly = 1;

        // 1000-cycle fetch wait with start pulsed in FETCH, then start in HALT
        do_reset();
        clear_rom();
        idly = 1000;
        rom[0] = 16'h1000; rom[1] = 16'hF000;
        run_prog(10, 0, hh);
        chk("p7_halted", 32'(halted), 32'd1);
        chk("p7_pc", 32'(pc), 32'd1);
        chk("p7_retired", 32'(retired), 32'd2);
        halt_hold(4);
        chk("p7_halt_stays", 32'(halted), 32'd1);
        idly = 1;

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
